gpio_in_sync_mux: RTL and testbench

Input-side counterpart of the GPIO output demux. Two external 8-bit input ports, port_a and port_b, are synchronized into the core clock domain. One port is selected by sel (0 = port_a, 1 = port_b). The selected value is debounced per bit, presented to the core as gpio_in, and rising edges are latched into sticky flags with an interrupt request.

---
 rtl/gpio_in_sync_mux.sv | 97 +++++++++
 tb/tb_gpio_in_sync_mux.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_sync_mux.sv
// Input GPIO path: two pin banks synchronized into clk, one selected by sel,
// debounced per bit, with sticky masked rising-edge flags and an irq.
module gpio_in_sync_mux #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] port_a,
  input  logic [WIDTH-1:0] port_b,
  input  logic             sel,
  input  logic [WIDTH-1:0] edge_mask,
  input  logic [WIDTH-1:0] edge_clr,
  output logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] edge_flags,
  output logic             irq
);

  localparam int CW = $clog2(DEB_CYCLES) + 1;

  logic [WIDTH-1:0] a_pipe [SYNC_STAGES];
  logic [WIDTH-1:0] b_pipe [SYNC_STAGES];
  logic [WIDTH-1:0] a_sync;
  logic [WIDTH-1:0] b_sync;
  logic             sel_q;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] gpio_next;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] flags_next;
  logic             switch_now;

  // Both banks are synchronized all the time so a port switch sees settled data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        a_pipe[s] <= '0;
        b_pipe[s] <= '0;
      end
    end else begin
      a_pipe[0] <= port_a;
      b_pipe[0] <= port_b;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        a_pipe[s] <= a_pipe[s-1];
        b_pipe[s] <= b_pipe[s-1];
      end
    end
  end

  assign a_sync     = a_pipe[SYNC_STAGES-1];
  assign b_sync     = b_pipe[SYNC_STAGES-1];
  assign raw        = sel_q ? b_sync : a_sync;
  assign switch_now = (sel != sel_q);

  always_comb begin
    gpio_next = gpio_in;
    for (int i = 0; i < WIDTH; i++) cnt_next[i] = cnt[i];
    if (switch_now) begin
      // A port switch loads the new port directly, bypassing the filter.
      gpio_next = sel ? b_sync : a_sync;
      for (int i = 0; i < WIDTH; i++) cnt_next[i] = '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (raw[i] == gpio_in[i]) begin
          cnt_next[i] = '0;
        end else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
          gpio_next[i] = raw[i];
          cnt_next[i]  = '0;
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  assign rise       = gpio_next & ~gpio_in & edge_mask & {WIDTH{~switch_now}};
  assign flags_next = rise | (edge_flags & ~edge_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q      <= 1'b0;
      gpio_in    <= '0;
      edge_flags <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sel_q      <= sel;
      gpio_in    <= gpio_next;
      edge_flags <= flags_next;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
    end
  end

  assign irq = |edge_flags;

endmodule

// File: tb/tb_gpio_in_sync_mux.sv
// Directed bench for gpio_in_sync_mux: latency, glitch rejection, port
// switching, edge flags with clear priority, and mid-operation reset.
module tb_gpio_in_sync_mux;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] port_a;
  logic [7:0] port_b;
  logic       sel;
  logic [7:0] edge_mask;
  logic [7:0] edge_clr;
  logic [7:0] gpio_in;
  logic [7:0] edge_flags;
  logic       irq;

  int n_checks = 0;
  int n_fail   = 0;

  gpio_in_sync_mux #(.WIDTH(8), .SYNC_STAGES(2), .DEB_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .port_a     (port_a),
    .port_b     (port_b),
    .sel        (sel),
    .edge_mask  (edge_mask),
    .edge_clr   (edge_clr),
    .gpio_in    (gpio_in),
    .edge_flags (edge_flags),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    rst = 1'b1; port_a = 8'h00; port_b = 8'h00; sel = 1'b0;
    edge_mask = 8'h00; edge_clr = 8'h00;
    tick(); tick();
    n_checks++;
    if (gpio_in !== 8'h00) begin n_fail++; $display("FAIL reset_gpio_in: got %h want 00", gpio_in); end
    n_checks++;
    if (edge_flags !== 8'h00) begin n_fail++; $display("FAIL reset_edge_flags: got %h want 00", edge_flags); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    rst = 1'b0;
    port_a = 8'hA5;
    for (int e = 0; e < 6; e++) begin
      tick();
      exp = (e < 5) ? 8'h00 : 8'hA5;
      n_checks++;
      if (gpio_in !== exp) begin
        n_fail++; $display("FAIL latency_edge%0d: got %h want %h", e, gpio_in, exp);
      end
    end
  endtask

  task automatic test_glitch();
    port_a = 8'h00;
    repeat (8) tick();
    n_checks++;
    if (gpio_in !== 8'h00) begin n_fail++; $display("FAIL glitch_pre: got %h want 00", gpio_in); end
    edge_mask = 8'hFF;
    port_a = 8'h01;
    repeat (3) tick();
    port_a = 8'h00;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (gpio_in !== 8'h00) begin n_fail++; $display("FAIL glitch_gpio_c%0d: got %h want 00", c, gpio_in); end
      n_checks++;
      if (edge_flags !== 8'h00) begin n_fail++; $display("FAIL glitch_flags_c%0d: got %h want 00", c, edge_flags); end
    end
  endtask

  task automatic test_port_switch();
    port_b = 8'h3C;
    repeat (3) tick();
    sel = 1'b1;
    tick();
    n_checks++;
    if (gpio_in !== 8'h3C) begin n_fail++; $display("FAIL switch_gpio: got %h want 3c", gpio_in); end
    n_checks++;
    if (edge_flags !== 8'h00) begin n_fail++; $display("FAIL switch_flags: got %h want 00", edge_flags); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL switch_irq: got %b want 0", irq); end
    repeat (6) tick();
    n_checks++;
    if (gpio_in !== 8'h3C) begin n_fail++; $display("FAIL switch_hold: got %h want 3c", gpio_in); end
    n_checks++;
    if (edge_flags !== 8'h00) begin n_fail++; $display("FAIL switch_hold_flags: got %h want 00", edge_flags); end
    sel = 1'b0;
    tick();
    n_checks++;
    if (gpio_in !== 8'h00) begin n_fail++; $display("FAIL switch_back: got %h want 00", gpio_in); end
  endtask

  task automatic test_edge_flags();
    edge_mask = 8'h01;
    port_a = 8'h03;
    repeat (5) tick();
    n_checks++;
    if (gpio_in !== 8'h00) begin n_fail++; $display("FAIL edge_early: got %h want 00", gpio_in); end
    tick();
    n_checks++;
    if (gpio_in !== 8'h03) begin n_fail++; $display("FAIL edge_gpio: got %h want 03", gpio_in); end
    n_checks++;
    if (edge_flags !== 8'h01) begin n_fail++; $display("FAIL edge_flags_set: got %h want 01", edge_flags); end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL edge_irq_set: got %b want 1", irq); end
    edge_clr = 8'h01;
    tick();
    edge_clr = 8'h00;
    n_checks++;
    if (edge_flags !== 8'h00) begin n_fail++; $display("FAIL edge_clear: got %h want 00", edge_flags); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL edge_irq_clear: got %b want 0", irq); end
  endtask

  task automatic test_set_wins();
    port_a = 8'h00;
    repeat (6) tick();
    n_checks++;
    if (gpio_in !== 8'h00) begin n_fail++; $display("FAIL fall_gpio: got %h want 00", gpio_in); end
    n_checks++;
    if (edge_flags !== 8'h00) begin n_fail++; $display("FAIL fall_no_flag: got %h want 00", edge_flags); end
    port_a = 8'h01;
    repeat (6) tick();
    n_checks++;
    if (edge_flags !== 8'h01) begin n_fail++; $display("FAIL set_flag: got %h want 01", edge_flags); end
    edge_mask = 8'h00;
    tick();
    n_checks++;
    if (edge_flags !== 8'h01) begin n_fail++; $display("FAIL mask_keeps_flag: got %h want 01", edge_flags); end
    edge_mask = 8'h01;
    port_a = 8'h00;
    repeat (6) tick();
    n_checks++;
    if (edge_flags !== 8'h01) begin n_fail++; $display("FAIL fall_keeps_flag: got %h want 01", edge_flags); end
    port_a = 8'h01;
    repeat (5) tick();
    edge_clr = 8'h01;
    tick();
    edge_clr = 8'h00;
    n_checks++;
    if (gpio_in !== 8'h01) begin n_fail++; $display("FAIL setwin_gpio: got %h want 01", gpio_in); end
    n_checks++;
    if (edge_flags !== 8'h01) begin n_fail++; $display("FAIL setwin_flags: got %h want 01", edge_flags); end
    tick();
    n_checks++;
    if (edge_flags !== 8'h01) begin n_fail++; $display("FAIL setwin_hold: got %h want 01", edge_flags); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    edge_mask = 8'hFF;
    port_a = 8'h81;
    repeat (4) tick();
    n_checks++;
    if (gpio_in !== 8'h01) begin n_fail++; $display("FAIL mid_pre_gpio: got %h want 01", gpio_in); end
    #2;
    rst = 1'b1;
    port_a = 8'h80;
    #1;
    n_checks++;
    if (gpio_in !== 8'h00) begin n_fail++; $display("FAIL mid_rst_gpio: got %h want 00", gpio_in); end
    n_checks++;
    if (edge_flags !== 8'h00) begin n_fail++; $display("FAIL mid_rst_flags: got %h want 00", edge_flags); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_rst_irq: got %b want 0", irq); end
    tick();
    rst = 1'b0;
    for (int e = 0; e < 6; e++) begin
      tick();
      exp = (e < 5) ? 8'h00 : 8'h80;
      n_checks++;
      if (gpio_in !== exp) begin
        n_fail++; $display("FAIL post_rst_edge%0d: got %h want %h", e, gpio_in, exp);
      end
    end
    n_checks++;
    if (edge_flags !== 8'h80) begin n_fail++; $display("FAIL post_rst_flags: got %h want 80", edge_flags); end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL post_rst_irq: got %b want 1", irq); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_port_switch();
    test_edge_flags();
    test_set_wins();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
